vcr_master: RTL and testbench
=============================

Name: vcr_master

Overview:
- Initiator side of the Vendor Command/Request (VCR) byte interface.
- Drives CS, the 8-bit VCR address/data bus and the clk_vcr_addr/clk_vcr_data strobes toward an FPGA-side VCR responder, and captures the responder's read bus.
- Sits in controller logic and test harnesses that issue VCR transactions (set app mode, echo, get IO status, reset) without the EZ-USB processor.
- The responder resynchronises strobes into its own IFCLK domain, so every strobe phase is stretched to a programmable number of cycles.

Parameters:
- STROBE_CYCLES, 4: IFCLK cycles per strobe low phase and per strobe high phase. Must be >= 3 to survive the responder's 2-flop synchroniser plus edge detect.
- LEN_W, 4: width of the byte count. Maximum transfer is 2^LEN_W-1 data bytes.
- TIMEOUT_CYCLES, 1024: write-data wait limit. Used only with VCR_MASTER_TIMEOUT_EN.

Ports:
- IFCLK  in  1  sole clock.
- RESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  8  VCR address, e.g. 8'h82 SET_APP_MODE.
- cmd_read  in  1  1 = read bytes from responder, 0 = write bytes.
- cmd_len  in  LEN_W  data byte count; 0 = address-only command.
- wr_data  in  8  write byte.
- wr_valid  in  1  write byte available.
- wr_ready  out  1  one-cycle accept of wr_data.
- rd_data  out  8  captured read byte.
- rd_valid  out  1  one-cycle pulse, no backpressure.
- done  out  1  one-cycle pulse at transaction end.
- err  out  1  one-cycle pulse on timeout abort. Tied 0 without the macro.
- vcr_cs  out  1  chip select to responder.
- vcr_dout  out  8  to responder vcr_in.
- vcr_din  in  8  from responder vcr_out.
- vcr_clk_addr  out  1  address strobe.
- vcr_clk_data  out  1  data strobe.

Behaviour:
- Reset values: state IDLE; vcr_cs, vcr_clk_addr, vcr_clk_data, wr_ready, rd_valid, done, err = 0; vcr_dout = 0; rd_data = 0. cmd_ready = 1 once reset deasserts.
- A reset mid-transaction drops both strobes and CS immediately. Any strobe in flight is abandoned; no done pulse.
- States: IDLE, ADDR_LO, ADDR_HI, DATA_LO, DATA_HI, TAIL, FIN. The phase counter counts 0..STROBE_CYCLES-1; the byte counter counts remaining bytes.
- IDLE:
  - On cmd_valid & cmd_ready (accept cycle t0), latch addr, read and len.
  - Next cycle: vcr_cs=1, vcr_dout=addr, go to ADDR_LO.
- ADDR_LO, S cycles: strobe low, address set up.
- ADDR_HI, S cycles: vcr_clk_addr=1. On exit go to DATA_LO if len>0, else TAIL.
- DATA_LO, write:
  - First cycle waits for wr_valid. wr_ready pulses in the cycle wr_valid is seen; vcr_dout takes wr_data the next cycle.
  - The phase counter runs only after the byte is held. While waiting, strobes stay low and CS stays high.
- DATA_LO, read: on the last phase cycle, rd_data <= vcr_din; rd_valid pulses in the following cycle. The responder output has settled by then (S >= 3 after the previous strobe edge).
- DATA_HI, S cycles: vcr_clk_data=1. Decrement the byte counter. Go to DATA_LO if bytes remain, else TAIL.
- TAIL, S cycles: all strobes low, guaranteeing the final edge is synchronised by the responder. Then FIN.
- FIN, 1 cycle: done=1, vcr_cs=0, vcr_dout=0; next state IDLE.
- Latency with no write stalls: done asserts at t0 + 1 + S*(3 + 2*len).
- Strobes:
  - Only one strobe is ever high at a time.
  - vcr_dout is stable for the whole high phase and the preceding low phase.
  - Strobes never glitch; both are registered outputs.
- cmd_valid during a busy transaction is ignored (cmd_ready=0); no queuing.
- cmd_len is modulo its width; 0 is legal.

Optional Feature:
- VCR_MASTER_TIMEOUT_EN defined:
  - A write-data wait counter counts cycles in DATA_LO waiting for wr_valid.
  - At TIMEOUT_CYCLES it aborts: go to TAIL with no data strobe, err pulses at the start of TAIL, FIN still pulses done.
  - The counter clears on each accepted byte.
- Macro undefined: the wait is unbounded, err is constant 0 and no counter logic is synthesised.

Test Plan:
- Address-only 8'h80, S=4 -> vcr_clk_addr high 4 cycles with vcr_dout=8'h80; no vcr_clk_data edge; done at t0+13.
- Write 8'h82 len1 data 8'h03 -> wr_ready pulses once; one data strobe with vcr_dout=8'h03; responder app_mode=8'h03; done at t0+21.
- Echo write 8'h88 len4 {11,22,33,44}, then read 8'h88 len4 -> rd_valid pulses 4 times with {4B,78,69,1E}.
- Read 8'h8A len1, responder FPGA_ID=3'd5 -> rd_data=8'h05, one rd_valid, done.
- Write len2 with wr_valid withheld 50 cycles before byte 2 -> strobes low, CS high during the stall; completes normally. With the macro and TIMEOUT_CYCLES=16 -> err pulse, only 1 data strobe, done.
- RESET asserted during DATA_HI -> vcr_clk_data and vcr_cs fall in the same cycle, no done; the next command runs cleanly from IDLE.

Source files
------------

// File: rtl/vcr_master.sv
// vcr_master: initiator side of the VCR byte interface.
//
// Drives chip select, the 8-bit address/data bus and the address/data strobes
// toward an FPGA-side VCR responder, and captures the responder's read bus.
// Each strobe phase is held for STROBE_CYCLES IFCLK cycles. This lets the
// responder resynchronise the strobes into its own clock domain.
//
// Ports:
//   IFCLK, RESET           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_addr/read/len      VCR address, direction, data byte count (0 = address only)
//   wr_data/valid/ready    write byte stream; wr_ready is a one-cycle accept
//   rd_data/rd_valid       captured read byte, one-cycle pulse, no backpressure
//   done, err              end-of-transaction pulse, timeout-abort pulse
//   vcr_cs, vcr_dout       chip select and bus toward the responder
//   vcr_din                responder read bus
//   vcr_clk_addr/data      registered address / data strobes
//
// Optional: define VCR_MASTER_TIMEOUT_EN to bound the write-data wait to
// TIMEOUT_CYCLES. If the limit is reached, the transaction aborts with an err pulse.
// Without the macro the wait has no limit and err is tied low.

module vcr_master #(
  parameter int STROBE_CYCLES  = 4,
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             IFCLK,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_addr,
  input  logic             cmd_read,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             vcr_cs,
  output logic [7:0]       vcr_dout,
  input  logic [7:0]       vcr_din,
  output logic             vcr_clk_addr,
  output logic             vcr_clk_data
);

  localparam int PH_W = $clog2(STROBE_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, DATA_LO, DATA_HI, TAIL, FIN} state_t;

  state_t           state_q, state_n;
  logic [PH_W-1:0]  ph_q, ph_n;
  logic [LEN_W-1:0] cnt_q, cnt_n;      // data bytes still to transfer
  logic             rd_q, rd_n;
  logic             held_q, held_n;    // write byte accepted for this data slot
  logic             cs_q, cs_n, ca_q, ca_n, cd_q, cd_n;
  logic             done_q, done_n, rdv_q, rdv_n;
  logic [7:0]       dout_q, dout_n, rdd_q, rdd_n;
  logic             ph_end;

`ifdef VCR_MASTER_TIMEOUT_EN
  localparam int WT_W = $clog2(TIMEOUT_CYCLES);
  logic [WT_W-1:0]  wt_q, wt_n;
  logic             err_q, err_n;
`endif

  assign ph_end    = (ph_q == PH_LAST);
  assign cmd_ready = (state_q == IDLE);
  // Accept is combinational, so a byte can be taken in the first DATA_LO cycle
  // and that cycle still counts as phase 0 of the low phase.
  assign wr_ready  = (state_q == DATA_LO) && !rd_q && !held_q && wr_valid;

  always_comb begin
    state_n = state_q;
    ph_n    = ph_q;
    cnt_n   = cnt_q;
    rd_n    = rd_q;
    held_n  = held_q;
    cs_n    = cs_q;
    ca_n    = ca_q;
    cd_n    = cd_q;
    dout_n  = dout_q;
    rdd_n   = rdd_q;
    done_n  = 1'b0;
    rdv_n   = 1'b0;
`ifdef VCR_MASTER_TIMEOUT_EN
    wt_n    = wt_q;
    err_n   = 1'b0;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_n = ADDR_LO;
        ph_n    = '0;
        cnt_n   = cmd_len;
        rd_n    = cmd_read;
        cs_n    = 1'b1;
        dout_n  = cmd_addr;
`ifdef VCR_MASTER_TIMEOUT_EN
        wt_n    = '0;
`endif
      end
      ADDR_LO: begin
        ph_n = ph_q + PH_W'(1);
        if (ph_end) begin
          state_n = ADDR_HI;
          ph_n    = '0;
          ca_n    = 1'b1;
        end
      end
      ADDR_HI: begin
        ph_n = ph_q + PH_W'(1);
        if (ph_end) begin
          ph_n    = '0;
          ca_n    = 1'b0;
          held_n  = 1'b0;
          state_n = (cnt_q != '0) ? DATA_LO : TAIL;
        end
      end
      DATA_LO: begin
        if (!rd_q && !held_q) begin
          // The phase counter is held at 0 until a write byte is on the bus.
          if (wr_valid) begin
            dout_n = wr_data;
            held_n = 1'b1;
            ph_n   = PH_W'(1);
`ifdef VCR_MASTER_TIMEOUT_EN
            wt_n   = '0;
`endif
          end
`ifdef VCR_MASTER_TIMEOUT_EN
          else if (wt_q == WT_W'(TIMEOUT_CYCLES - 1)) begin
            state_n = TAIL;
            ph_n    = '0;
            err_n   = 1'b1;
            wt_n    = '0;
          end else begin
            wt_n = wt_q + WT_W'(1);
          end
`endif
        end else if (ph_end) begin
          state_n = DATA_HI;
          ph_n    = '0;
          cd_n    = 1'b1;
          if (rd_q) begin
            // Responder output has settled a full low phase after the last edge.
            rdd_n = vcr_din;
            rdv_n = 1'b1;
          end
        end else begin
          ph_n = ph_q + PH_W'(1);
        end
      end
      DATA_HI: begin
        ph_n = ph_q + PH_W'(1);
        if (ph_end) begin
          ph_n    = '0;
          cd_n    = 1'b0;
          held_n  = 1'b0;
          cnt_n   = cnt_q - LEN_W'(1);
          state_n = (cnt_q != LEN_W'(1)) ? DATA_LO : TAIL;
        end
      end
      TAIL: begin
        // Quiet period so the responder synchronises the final strobe edge.
        ph_n = ph_q + PH_W'(1);
        if (ph_end) begin
          state_n = FIN;
          ph_n    = '0;
          done_n  = 1'b1;
          cs_n    = 1'b0;
          dout_n  = '0;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge IFCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      held_q  <= 1'b0;
      cs_q    <= 1'b0;
      ca_q    <= 1'b0;
      cd_q    <= 1'b0;
      dout_q  <= '0;
      rdd_q   <= '0;
      done_q  <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      ph_q    <= ph_n;
      cnt_q   <= cnt_n;
      rd_q    <= rd_n;
      held_q  <= held_n;
      cs_q    <= cs_n;
      ca_q    <= ca_n;
      cd_q    <= cd_n;
      dout_q  <= dout_n;
      rdd_q   <= rdd_n;
      done_q  <= done_n;
      rdv_q   <= rdv_n;
    end
  end

`ifdef VCR_MASTER_TIMEOUT_EN
  always_ff @(posedge IFCLK or posedge RESET) begin
    if (RESET) begin
      wt_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wt_q  <= wt_n;
      err_q <= err_n;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign vcr_cs       = cs_q;
  assign vcr_dout     = dout_q;
  assign vcr_clk_addr = ca_q;
  assign vcr_clk_data = cd_q;
  assign rd_data      = rdd_q;
  assign rd_valid     = rdv_q;
  assign done         = done_q;

endmodule

// File: tb/tb_vcr_master.sv
module tb_vcr_master;
  localparam int S = 4;
`ifdef VCR_MASTER_TIMEOUT_EN
  localparam bit TO_EN  = 1'b1;
  localparam int TO_CYC = 16;
`else
  localparam bit TO_EN  = 1'b0;
  localparam int TO_CYC = 1024;
`endif

  logic IFCLK = 1'b0, RESET = 1'b1;
  logic cmd_valid = 1'b0, cmd_read = 1'b0, wr_valid = 1'b0;
  logic [7:0] cmd_addr = '0, wr_data = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] vcr_din = 8'h00;
  logic cmd_ready, wr_ready, rd_valid, done, err, vcr_cs, vcr_clk_addr, vcr_clk_data;
  logic [7:0] rd_data, vcr_dout;

  vcr_master #(.STROBE_CYCLES(S), .LEN_W(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .IFCLK(IFCLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_read(cmd_read), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .vcr_cs(vcr_cs), .vcr_dout(vcr_dout), .vcr_din(vcr_din),
    .vcr_clk_addr(vcr_clk_addr), .vcr_clk_data(vcr_clk_data));

  always #5 IFCLK = ~IFCLK;

  int cyc = 0;
  always @(posedge IFCLK) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Responder model + bus monitor. Read bytes are presented one at a time:
  // byte 0 after the address strobe, and each following byte after a data strobe.
  logic [7:0] rsp_arr [16];
  int rptr = 0, n_ca = 0, n_cd = 0, n_done = 0, n_err = 0, viol = 0;
  logic [7:0] addr_seen = '0, p_dout = '0;
  logic p_ca = 1'b0, p_cd = 1'b0;
  logic [7:0] wq[$], rq[$];

  always @(negedge IFCLK) begin
    if (vcr_clk_addr && !p_ca) begin
      n_ca++; addr_seen = vcr_dout; vcr_din = rsp_arr[0]; rptr = 1;
    end
    if (vcr_clk_data && !p_cd) begin
      n_cd++; wq.push_back(vcr_dout);
      if (rptr < 16) vcr_din = rsp_arr[rptr];
      rptr++;
    end
    if (vcr_clk_addr && vcr_clk_data) viol++;
    if ((vcr_clk_addr || vcr_clk_data) && !vcr_cs) viol++;
    if (((vcr_clk_addr && p_ca) || (vcr_clk_data && p_cd)) && vcr_dout != p_dout) viol++;
    if (rd_valid) rq.push_back(rd_data);
    if (done) n_done++;
    if (err) n_err++;
    p_ca = vcr_clk_addr; p_cd = vcr_clk_data; p_dout = vcr_dout;
  end

  typedef struct {
    logic [7:0]       addr;
    logic             rd;
    logic [3:0]       len;
    logic [15:0][7:0] dat;
    int stall_idx, stall_cyc, exp_lat, exp_nd, exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input logic r, input int len,
                              input logic [31:0] b, input int sidx, input int scyc,
                              input int nd, input int e);
    vec_t v;
    v.addr = a; v.rd = r; v.len = 4'(len);
    for (int i = 0; i < 16; i++) v.dat[i] = 8'(i * 37 + 1);
    v.dat[0] = b[31:24]; v.dat[1] = b[23:16]; v.dat[2] = b[15:8]; v.dat[3] = b[7:0];
    v.stall_idx = sidx; v.stall_cyc = scyc;
    v.exp_lat = (scyc > 0) ? 0 : 1 + S * (3 + 2 * len);
    v.exp_nd = nd; v.exp_err = e;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v, input string nm);
    int ca0, cd0, wq0, rq0, dn0, er0, t0, t_done, idx, since;
    bit got;
    for (int i = 0; i < 16; i++) rsp_arr[i] = v.dat[i];
    ca0 = n_ca; cd0 = n_cd; wq0 = wq.size(); rq0 = rq.size(); dn0 = n_done; er0 = n_err;
    @(negedge IFCLK);
    cmd_addr = v.addr; cmd_read = v.rd; cmd_len = v.len; cmd_valid = 1'b1; t0 = cyc;
    @(negedge IFCLK);
    // A second request while busy must be ignored.
    cmd_addr = ~v.addr; cmd_len = ~v.len;
    #1 chk({nm, ".busy_ready"}, int'(cmd_ready), 0);
    @(negedge IFCLK);
    cmd_valid = 1'b0;
    idx = 0; since = 0; got = 0; t_done = 0;
    for (int k = 0; k < 4000; k++) begin
      wr_valid = !v.rd && idx < int'(v.len) && !(idx == v.stall_idx && since < v.stall_cyc);
      wr_data  = wr_valid ? v.dat[idx] : 8'($urandom);
      #1;
      if (wr_ready) begin idx++; since = 0; end else since++;
      if (v.stall_cyc > 0 && idx == v.stall_idx && since == 2 * S + 5) begin
        chk({nm, ".stall_cs"}, int'(vcr_cs), 1);
        chk({nm, ".stall_strobes"}, int'(vcr_clk_addr | vcr_clk_data), 0);
      end
      if (done) begin got = 1; t_done = cyc; break; end
      @(negedge IFCLK);
    end
    wr_valid = 1'b0;
    repeat (2) @(negedge IFCLK);
    chk({nm, ".done_seen"}, int'(got), 1);
    if (got && v.exp_lat > 0) chk({nm, ".latency"}, t_done - t0, v.exp_lat);
    chk({nm, ".done_cnt"}, n_done - dn0, 1);
    chk({nm, ".addr_strobes"}, n_ca - ca0, 1);
    chk({nm, ".addr"}, int'(addr_seen), int'(v.addr));
    chk({nm, ".data_strobes"}, n_cd - cd0, v.exp_nd);
    chk({nm, ".err_cnt"}, n_err - er0, v.exp_err);
    if (!v.rd) begin
      chk({nm, ".wr_ready_cnt"}, idx, v.exp_nd);
      for (int i = 0; i < v.exp_nd && wq0 + i < wq.size(); i++)
        chk({nm, ".wbyte"}, int'(wq[wq0 + i]), int'(v.dat[i]));
    end else begin
      chk({nm, ".rd_valid_cnt"}, rq.size() - rq0, int'(v.len));
      for (int i = 0; i < int'(v.len) && rq0 + i < rq.size(); i++)
        chk({nm, ".rbyte"}, int'(rq[rq0 + i]), int'(v.dat[i]));
    end
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    int dn0;
    bit seen;
    tbl[0] = mk(8'h80, 0, 0,  32'h0,        -1, 0,  0, 0);
    tbl[1] = mk(8'h82, 0, 1,  32'h03000000, -1, 0,  1, 0);
    tbl[2] = mk(8'h88, 0, 4,  32'h11223344, -1, 0,  4, 0);
    tbl[3] = mk(8'h88, 1, 4,  32'h4B78691E, -1, 0,  4, 0);
    tbl[4] = mk(8'h8A, 1, 1,  32'h05000000, -1, 0,  1, 0);
    tbl[5] = mk(8'h84, 0, 2,  32'hA55A0000, 1, 50, TO_EN ? 1 : 2, TO_EN ? 1 : 0);
    tbl[6] = mk(8'h8C, 1, 15, 32'hDEADBEEF, -1, 0, 15, 0);

    repeat (3) @(negedge IFCLK);
    chk("rst_cs", int'(vcr_cs), 0);
    chk("rst_strobes", int'(vcr_clk_addr | vcr_clk_data), 0);
    chk("rst_dout", int'(vcr_dout), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_pulses", int'({rd_valid, done, err, wr_ready}), 0);
    RESET = 1'b0;
    @(negedge IFCLK);
    chk("rst_cmd_ready", int'(cmd_ready), 1);

    for (int i = 0; i < 7; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      rv = mk(8'($urandom), 1'($urandom), $urandom_range(0, 15), $urandom, -1, 0, 0, 0);
      for (int j = 4; j < 16; j++) rv.dat[j] = 8'($urandom);
      rv.exp_nd = int'(rv.len);
      run_cmd(rv, $sformatf("rnd%0d", i));
    end

    // Reset while the data strobe is high.
    dn0 = n_done; seen = 0;
    @(negedge IFCLK);
    cmd_addr = 8'h84; cmd_read = 1'b0; cmd_len = 4'd2; cmd_valid = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h77;
    @(negedge IFCLK);
    cmd_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (vcr_clk_data) begin seen = 1; break; end
      @(negedge IFCLK);
    end
    chk("mid_rst.strobe_reached", int'(seen), 1);
    RESET = 1'b1;
    #1;
    chk("mid_rst.clk_data", int'(vcr_clk_data), 0);
    chk("mid_rst.cs", int'(vcr_cs), 0);
    wr_valid = 1'b0;
    repeat (3) @(negedge IFCLK);
    RESET = 1'b0;
    repeat (3) @(negedge IFCLK);
    chk("mid_rst.no_done", n_done - dn0, 0);
    chk("mid_rst.cmd_ready", int'(cmd_ready), 1);
    run_cmd(tbl[1], "post_rst");

    chk("protocol_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end
endmodule
